// File: rtl/shift_reg_bank.sv
// rtl/shift_reg_bank.sv - multi-mode shift register bank with per-stage valid bits
// Hold / shift up / shift down / rotate, single-stage write, tap read and registered fill count.
module shift_reg_bank #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 9,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       si,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_vld,
  output logic [WIDTH-1:0]       so_hi,
  output logic [WIDTH-1:0]       so_lo,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [DEPTH-1:0]       vld,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] stage     [DEPTH];
  logic [WIDTH-1:0] nxt_stage [DEPTH];
  logic [DEPTH-1:0] nxt_vld;
  logic [CW-1:0]    nxt_fill;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_W);

  // The op is applied first; a write then overrides the shifted value at its stage.
  always_comb begin
    nxt_stage = stage;
    nxt_vld   = vld;
    case (op)
      2'b01: begin
        for (int i = DEPTH - 1; i > 0; i--) nxt_stage[i] = stage[i-1];
        nxt_stage[0] = si;
        nxt_vld      = {vld[DEPTH-2:0], 1'b1};
      end
      2'b10: begin
        for (int i = 0; i < DEPTH - 1; i++) nxt_stage[i] = stage[i+1];
        nxt_stage[DEPTH-1] = si;
        nxt_vld            = {1'b1, vld[DEPTH-1:1]};
      end
      2'b11: begin
        for (int i = DEPTH - 1; i > 0; i--) nxt_stage[i] = stage[i-1];
        nxt_stage[0] = stage[DEPTH-1];
        nxt_vld      = {vld[DEPTH-2:0], vld[DEPTH-1]};
      end
      default: ;
    endcase
    if (wr_en && wr_ok) begin
      nxt_stage[wr_addr] = wr_data;
      nxt_vld[wr_addr]   = 1'b1;
    end
  end

  always_comb begin
    nxt_fill = '0;
    for (int i = 0; i < DEPTH; i++) nxt_fill = nxt_fill + CW'(nxt_vld[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      vld  <= '0;
      fill <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      vld  <= '0;
      fill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= nxt_stage[i];
      vld  <= nxt_vld;
      fill <= nxt_fill;
    end
  end

  always_comb begin
    taps = '0;
    for (int i = 0; i < DEPTH; i++) taps[i*WIDTH +: WIDTH] = stage[i];
  end

  always_comb begin
    rd_data = '0;
    rd_vld  = 1'b0;
    if (rd_ok) begin
      rd_data = stage[rd_addr];
      rd_vld  = vld[rd_addr];
    end
  end

  assign so_hi = stage[DEPTH-1];
  assign so_lo = stage[0];
  assign full  = (fill == CW'(DEPTH));

endmodule

// File: doc/shift_reg_bank.md
Name: shift_reg_bank

Overview:
- Parametrised multi-mode shift register bank: DEPTH stages of WIDTH bits each, with a per-stage valid bit.
- Supports hold, shift up, shift down and rotate, plus synchronous clear, single-stage random write and random tap read.
- Used as a configurable delay line and tap buffer in datapath blocks that need directional shifting and occupancy tracking.

Parameters:
- WIDTH, 4, bits per stage (>=1)
- DEPTH, 9, number of stages (>=2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- CW, $clog2(DEPTH+1), fill-count width (derived)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of all stages and valid bits
- op  in  2  00 hold, 01 shift up, 10 shift down, 11 rotate up
- si  in  WIDTH  serial input word
- wr_en  in  1  single-stage write enable
- wr_addr  in  AW  stage to write
- wr_data  in  WIDTH  write data
- rd_addr  in  AW  tap select
- rd_data  out  WIDTH  stage[rd_addr], combinational
- rd_vld  out  1  valid[rd_addr], combinational
- so_hi  out  WIDTH  stage[DEPTH-1]
- so_lo  out  WIDTH  stage[0]
- taps  out  WIDTH*DEPTH  all stages flattened; stage i at bits [i*WIDTH +: WIDTH]
- vld  out  DEPTH  per-stage valid bits
- fill  out  CW  popcount(vld), registered
- full  out  1  fill == DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): all stages = 0, vld = 0, fill = 0. All outputs read 0 while reset is asserted, including full.
- Priority per posedge: clr > (op, then wr_en). With clr=1, all stages and vld clear to 0 and fill goes to 0; op and wr_en are ignored.
- op=00 hold: no stage changes.
- op=01 shift up: stage[i+1] <= stage[i], vld[i+1] <= vld[i]; stage[0] <= si, vld[0] <= 1. Old stage[DEPTH-1] is discarded.
- op=10 shift down: stage[i] <= stage[i+1], vld[i] <= vld[i+1]; stage[DEPTH-1] <= si, vld[DEPTH-1] <= 1. Old stage[0] is discarded.
- op=11 rotate up: stage[0] <= old stage[DEPTH-1] (vld moves with data); si is ignored; fill is unchanged.
- wr_en=1 applies after the op in the same cycle: the next state at wr_addr = wr_data with vld = 1, overriding the shifted value at that position.
- wr_addr >= DEPTH: the write is dropped; the op still executes.
- rd_addr >= DEPTH: rd_data = 0, rd_vld = 0.
- fill is registered and equals popcount of the next vld. It must never exceed DEPTH.
- Shifting when full: fill stays DEPTH; the word shifted out is lost. There is no stall and no error flag.
- Shifting an invalid stage out of the bank lets fill increase; shifting out a valid stage when not full leaves fill unchanged.
- Data latency: si appears at so_hi after DEPTH shift-up cycles, and at so_lo after DEPTH shift-down cycles.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Test Plan:
- Reset, then 9 cycles op=01 with si=1..9 -> taps stage0..8 = 9,8,...,1; so_hi=1; fill=9; full=1.
- From the full state, op=11 once -> stage0=1, stage1=9, so_hi=2; fill stays 9. A further op=01 with si=A -> stage0=A, so_hi=3, fill=9.
- From reset, op=10 three cycles with si=5,6,7 -> stage8=7, stage7=6, stage6=5; vld=9'b111000000; fill=3; so_lo=0.
- op=01 si=3 with wr_en=1, wr_addr=0, wr_data=C in the same cycle -> stage0=C, vld[0]=1. wr_addr=9 (DEPTH=9) -> write dropped, shift still occurs.
- clr=1 with op=01 and wr_en=1 -> all stages 0, fill=0; rd_addr=12 -> rd_data=0, rd_vld=0.
- Drop rst_n between clock edges while full -> taps, vld and fill are 0 immediately. After release, the first op=01 with si=F gives fill=1, stage0=F.
